dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Sequencer in front of the single-port, word-wide data RAM. It turns CPU byte, halfword and word loads and stores, using MemOp encoding, into word-aligned RAM transactions. Sub-word stores are performed as read-modify-write, and load data is extracted and extended. An optional second requester (the boot/UART loader) shares the RAM through fixed-priority arbitration.

## Interface
Parameters:
- ADDR_W, 16, byte-address width; the RAM word index is addr[ADDR_W-1:2]
- DATA_W, 32, data width; fixed at 32, any other value is illegal

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_memop  in  3  000 word; 001 byte signed; 010 half signed; 101 byte unsigned; 110 half unsigned
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- cpu_ready  out  1  controller can accept a request this cycle
- cpu_done  out  1  one-cycle pulse when the access completes
- cpu_rdata  out  32  extended load data, valid while cpu_done=1
- cpu_err  out  1  one-cycle pulse on a rejected request
- ld_req, ld_addr[ADDR_W], ld_wdata[32]  in  loader word-write request (present only with the macro)
- ld_ready, ld_done  out  1  loader handshake (present only with the macro)
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W-2  RAM word index
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word, valid 1 cycle after ram_en=1 with ram_we=0

## Operation
- A request transfers when req&ready are both 1 on a rising edge. Address, memop, we and wdata are latched at transfer, so the requester need not hold them afterwards.
- ready=1 only in IDLE; it is 0 in every other state.
- States:
  - IDLE
  - RD: issue ram_en=1, ram_we=0
  - MRG: capture ram_rdata
  - WR: issue ram_en=1, ram_we=1
  - RSP: drive cpu_done
- Load: IDLE→RD→MRG→RSP→IDLE. In MRG the lane is selected and extended into a rdata register.
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Signed ops sign-extend bit 7 or bit 15; unsigned ops zero-fill.
- Word store: IDLE→WR→IDLE, with ram_wdata=wdata and cpu_done in WR.
- Sub-word store: IDLE→RD→MRG→WR→IDLE. MRG replaces only the addressed byte or half of the old word with wdata[7:0] or wdata[15:0]. cpu_done is asserted in WR.
- Rejected requests: the controller pulses cpu_err the cycle after transfer, issues no RAM access, does not assert done, and returns to IDLE. A request is rejected for either of:
  - misalignment: half with addr[0]=1, or word with addr[1:0]≠0
  - illegal memop: 011, 100, 111
- Stores of 101/110 are illegal and are rejected.

## Timing
- Reset values: all outputs 0 except cpu_ready, which is 1 (reset state IDLE).
- Reset asserted mid-operation aborts the access immediately. No further ram_we is issued and no done is pulsed.
- Latency from the transfer edge to the done pulse:
  - load: 3 cycles
  - word store: 1 cycle
  - sub-word store: 3 cycles
  - error pulse: 1 cycle
- Back-to-back: a new request can transfer on the edge following done, because ready is re-asserted in the cycle after RSP/WR.
- RAM outputs are registered; ram_wdata is stable for the whole WR cycle.

## Configuration
- DMEM_CTRL_LOADER_EN defined:
  - The ld_* ports exist; the loader issues word writes only (2 cycles: IDLE→WR).
  - If ld_req and cpu_req are both 1 in IDLE, the loader wins: ld_ready=1 and cpu_ready=0 that cycle.
  - ld_addr[1:0] is ignored.
- DMEM_CTRL_LOADER_EN undefined: the ld_* ports are absent and the CPU is the sole requester.

## Structure
- Package dmem_pkg holds:
  - MemOp localparams (MOP_W, MOP_B, MOP_H, MOP_BU, MOP_HU)
  - the state enum
  - a legal/misaligned check function
- Sub-module dmem_lane_fmt: combinational extract/extend for loads and merge for stores. Inputs are memop, addr[1:0], old word and wdata; outputs are rdata and merged word.

## Test plan
- Word store 0x12345678 @0x0010, then byte-signed load @0x0013 → cpu_rdata=0x00000012; halfword-unsigned load @0x0012 → 0x00001234.
- RAM word 0xAABBCCDD at index 4; byte store 0x5A @0x0011 → exactly one ram write, of 0xAABB5ADD, and done 3 cycles after transfer.
- RAM word 0x0000_80FF; half-signed load @0x0 → 0xFFFF80FF; byte-unsigned load @0x0 → 0x000000FF.
- Half load @0x0003, and a store with memop 101 → cpu_err pulse, ram_en never 1, cpu_done stays 0.
- Reset asserted during MRG of a sub-word store → ram_we stays 0, outputs return to their reset values, and the next request completes normally.
- (LOADER_EN) ld_req and cpu_req in the same cycle → loader word written first; CPU accepted 2 cycles later and completes correctly.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - MemOp encodings, controller states and request legality check
package dmem_pkg;

    localparam logic [2:0] MOP_W  = 3'b000;
    localparam logic [2:0] MOP_B  = 3'b001;
    localparam logic [2:0] MOP_H  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b101;
    localparam logic [2:0] MOP_HU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MRG,
        ST_WR,
        ST_RSP,
        ST_ERR
    } state_t;

    // 1 when the memop exists for this direction and the address is naturally aligned
    function automatic logic mop_ok(input logic we, input logic [2:0] op, input logic [1:0] a);
        logic ok;
        case (op)
            MOP_W:   ok = (a == 2'b00);
            MOP_B:   ok = 1'b1;
            MOP_H:   ok = ~a[0];
            MOP_BU:  ok = ~we;
            MOP_HU:  ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - load lane extract/extend and sub-word store merge
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // pick the addressed lane of the old word and extend it for loads
    always_comb begin
        byte_sel = old_word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = old_word[15:8];
            2'd2:    byte_sel = old_word[23:16];
            2'd3:    byte_sel = old_word[31:24];
            default: byte_sel = old_word[7:0];
        endcase
        half_sel = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        case (memop)
            MOP_B:   rdata = {{24{byte_sel[7]}}, byte_sel};
            MOP_BU:  rdata = {24'h0, byte_sel};
            MOP_H:   rdata = {{16{half_sel[15]}}, half_sel};
            MOP_HU:  rdata = {16'h0, half_sel};
            default: rdata = old_word;
        endcase
    end

    // overwrite only the addressed byte/half of the old word for stores
    always_comb begin
        merged = old_word;
        case (memop)
            MOP_B, MOP_BU: begin
                case (addr_lo)
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    2'd3:    merged[31:24] = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            MOP_H, MOP_HU: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            MOP_W:   merged = wdata;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data RAM sequencer (sub-word RMW, load extend); DMEM_CTRL_LOADER_EN adds loader port
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_memop,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
`ifdef DMEM_CTRL_LOADER_EN
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic              ld_done,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state, state_n;
    logic              cpu_take, ld_take;
    logic              ld_pend, ld_rdy_i, ld_done_i;
    logic [ADDR_W-3:0] ld_word;
    logic [DATA_W-1:0] ld_data;
    logic              we_q, ldr_q;
    logic [2:0]        op_q;
    logic [1:0]        lo_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] fmt_rdata, fmt_merged;

`ifdef DMEM_CTRL_LOADER_EN
    logic unused_ld_lo;
    assign ld_pend      = ld_req;
    assign ld_word      = ld_addr[ADDR_W-1:2];
    assign ld_data      = ld_wdata;
    assign ld_ready     = ld_rdy_i;
    assign ld_done      = ld_done_i;
    assign unused_ld_lo = ^ld_addr[1:0];
`else
    logic unused_ld;
    assign ld_pend   = 1'b0;
    assign ld_word   = '0;
    assign ld_data   = '0;
    assign unused_ld = ld_rdy_i ^ ld_done_i;
`endif

    dmem_lane_fmt u_fmt (
        .memop    (op_q),
        .addr_lo  (lo_q),
        .old_word (ram_rdata),
        .wdata    (wdata_q),
        .rdata    (fmt_rdata),
        .merged   (fmt_merged)
    );

    // state register; reset drops any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // next state, handshakes and pulses; loader beats the CPU in IDLE
    always_comb begin
        state_n   = state;
        cpu_ready = 1'b0;
        cpu_done  = 1'b0;
        cpu_err   = 1'b0;
        ld_rdy_i  = 1'b0;
        ld_done_i = 1'b0;
        cpu_take  = 1'b0;
        ld_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_ready = ~ld_pend;
                ld_rdy_i  = 1'b1;
                if (ld_pend) begin
                    ld_take = 1'b1;
                    state_n = ST_WR;
                end else if (cpu_req) begin
                    cpu_take = 1'b1;
                    if (!mop_ok(cpu_we, cpu_memop, cpu_addr[1:0])) state_n = ST_ERR;
                    else if (cpu_we && cpu_memop == MOP_W)          state_n = ST_WR;
                    else                                            state_n = ST_RD;
                end
            end
            ST_RD:  state_n = ST_MRG;
            ST_MRG: state_n = we_q ? ST_WR : ST_RSP;
            ST_WR: begin
                state_n   = ST_IDLE;
                cpu_done  = ~ldr_q;
                ld_done_i = ldr_q;
            end
            ST_RSP: begin
                state_n  = ST_IDLE;
                cpu_done = 1'b1;
            end
            ST_ERR: begin
                state_n = ST_IDLE;
                cpu_err = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // request latches and registered RAM port / load data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_rdata <= '0;
            we_q      <= 1'b0;
            ldr_q     <= 1'b0;
            op_q      <= MOP_W;
            lo_q      <= 2'b00;
            wdata_q   <= '0;
        end else begin
            ram_en <= (state_n == ST_RD) || (state_n == ST_WR);
            ram_we <= (state_n == ST_WR);
            if (ld_take) begin
                ldr_q     <= 1'b1;
                ram_addr  <= ld_word;
                ram_wdata <= ld_data;
            end else if (cpu_take) begin
                ldr_q    <= 1'b0;
                we_q     <= cpu_we;
                op_q     <= cpu_memop;
                lo_q     <= cpu_addr[1:0];
                wdata_q  <= cpu_wdata;
                ram_addr <= cpu_addr[ADDR_W-1:2];
                if (cpu_we && cpu_memop == MOP_W) ram_wdata <= cpu_wdata;
            end
            if (state == ST_MRG) begin
                if (we_q) ram_wdata <= fmt_merged;
                else      cpu_rdata <= fmt_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector bench for dmem_ctrl with a behavioural RAM
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_memop;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef DMEM_CTRL_LOADER_EN
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready, ld_done;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_memop (cpu_memop),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
`ifdef DMEM_CTRL_LOADER_EN
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
`endif
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // single-port synchronous RAM with access counters
    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp;   // load result, or RAM word after a store
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [2:0] op, logic [15:0] addr, logic [31:0] wdata,
                                logic err, logic [31:0] exp, int lat);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
        v.err = err; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic access(input string tag, input vec_t v);
        int lat = 0;
        int guard = 0;
        int wr0, en0;
        logic gd = 1'b0, ge = 1'b0;
        logic [31:0] rd = 32'h0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_memop = v.op;
        cpu_addr = v.addr; cpu_wdata = v.wdata;
        #1;
        while (!cpu_ready && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        chk({tag, "_ready"}, {31'h0, cpu_ready}, 32'h1);
        wr0 = wr_cnt; en0 = en_cnt;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                cpu_req = 1'b0; cpu_we = ~v.we; cpu_memop = 3'b111;
                cpu_addr = 16'hFFFF; cpu_wdata = 32'h0BAD0BAD;
            end
            if (cpu_done || cpu_err) begin
                lat = k; gd = cpu_done; ge = cpu_err; rd = cpu_rdata;
                break;
            end
        end
        chk({tag, "_lat"}, lat, v.lat);
        chk({tag, "_done_err"}, {30'h0, gd, ge}, v.err ? 32'h1 : 32'h2);
        if (!v.err && !v.we) chk({tag, "_rdata"}, rd, v.exp);
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, {29'h0, cpu_ready, cpu_done, cpu_err}, 32'h4);
        chk({tag, "_ram_writes"}, wr_cnt - wr0, (v.we && !v.err) ? 1 : 0);
        if (v.err) chk({tag, "_ram_en"}, en_cnt - en0, 0);
        if (v.we && !v.err) chk({tag, "_mem"}, mem[v.addr[15:2]], v.exp);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_memop = MOP_W;
        cpu_addr = 16'h0; cpu_wdata = 32'h0;
`ifdef DMEM_CTRL_LOADER_EN
        ld_req = 1'b0; ld_addr = 16'h0; ld_wdata = 32'h0;
`endif

        vecs.push_back(mk(1, MOP_W,  16'h0010, 32'h12345678, 0, 32'h12345678, 1));
        vecs.push_back(mk(0, MOP_B,  16'h0013, 32'h0,        0, 32'h00000012, 3));
        vecs.push_back(mk(0, MOP_HU, 16'h0012, 32'h0,        0, 32'h00001234, 3));
        vecs.push_back(mk(0, MOP_H,  16'h0010, 32'h0,        0, 32'h00005678, 3));
        vecs.push_back(mk(0, MOP_BU, 16'h0011, 32'h0,        0, 32'h00000056, 3));
        vecs.push_back(mk(1, MOP_W,  16'h0010, 32'hAABBCCDD, 0, 32'hAABBCCDD, 1));
        vecs.push_back(mk(1, MOP_B,  16'h0011, 32'hFFFFFF5A, 0, 32'hAABB5ADD, 3));
        vecs.push_back(mk(0, MOP_B,  16'h0011, 32'h0,        0, 32'h0000005A, 3));
        vecs.push_back(mk(1, MOP_W,  16'h0000, 32'h000080FF, 0, 32'h000080FF, 1));
        vecs.push_back(mk(0, MOP_H,  16'h0000, 32'h0,        0, 32'hFFFF80FF, 3));
        vecs.push_back(mk(0, MOP_BU, 16'h0000, 32'h0,        0, 32'h000000FF, 3));
        vecs.push_back(mk(0, MOP_B,  16'h0000, 32'h0,        0, 32'hFFFFFFFF, 3));
        vecs.push_back(mk(1, MOP_H,  16'h0002, 32'h1234BEEF, 0, 32'hBEEF80FF, 3));
        vecs.push_back(mk(0, MOP_HU, 16'h0002, 32'h0,        0, 32'h0000BEEF, 3));
        vecs.push_back(mk(0, MOP_H,  16'h0002, 32'h0,        0, 32'hFFFFBEEF, 3));
        vecs.push_back(mk(1, MOP_B,  16'h0003, 32'h00000011, 0, 32'h11EF80FF, 3));
        vecs.push_back(mk(0, MOP_W,  16'h0000, 32'h0,        0, 32'h11EF80FF, 3));
        vecs.push_back(mk(1, MOP_BU, 16'h0000, 32'h000000AA, 1, 32'h0, 1));
        vecs.push_back(mk(0, MOP_H,  16'h0003, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, MOP_W,  16'h0002, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b011, 16'h0000, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b100, 16'h0000, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, 3'b111, 16'h0000, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, MOP_HU, 16'h0000, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, MOP_H,  16'h0001, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(1, MOP_W,  16'h0001, 32'h0,        1, 32'h0, 1));
        vecs.push_back(mk(0, MOP_W,  16'h0000, 32'h0,        0, 32'h11EF80FF, 3));
        vecs.push_back(mk(1, MOP_B,  16'h0000, 32'h000000AB, 0, 32'h11EF80AB, 3));

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, cpu_ready}, 32'h1);
        chk("rst_pulses", {30'h0, cpu_done, cpu_err}, 32'h0);
        chk("rst_ram_ctl", {30'h0, ram_en, ram_we}, 32'h0);
        chk("rst_ram_addr", {18'h0, ram_addr}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) access($sformatf("v%0d", i), vecs[i]);

        // reset during MRG of a byte store: no write, outputs back to reset values
        begin
            int wr0;
            wr0 = wr_cnt;
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_memop = MOP_B;
            cpu_addr = 16'h0011; cpu_wdata = 32'h00000077;
            @(posedge clk); #1;
            cpu_req = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            chk("mrg_rst_ready", {31'h0, cpu_ready}, 32'h1);
            chk("mrg_rst_ram_ctl", {30'h0, ram_en, ram_we}, 32'h0);
            chk("mrg_rst_ram_addr", {18'h0, ram_addr}, 32'h0);
            chk("mrg_rst_ram_wdata", ram_wdata, 32'h0);
            chk("mrg_rst_rdata", cpu_rdata, 32'h0);
            repeat (2) @(posedge clk);
            #1;
            chk("mrg_rst_pulses", {30'h0, cpu_done, cpu_err}, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("mrg_rst_no_write", wr_cnt - wr0, 0);
            chk("mrg_rst_mem", mem[4], 32'hAABB5ADD);
            access("post_rst_hu", mk(0, MOP_HU, 16'h0012, 32'h0, 0, 32'h0000AABB, 3));
            access("post_rst_w",  mk(0, MOP_W,  16'h0010, 32'h0, 0, 32'hAABB5ADD, 3));
        end

`ifdef DMEM_CTRL_LOADER_EN
        // loader and CPU collide: loader word first, CPU load of that word follows
        begin
            int lat = 0;
            @(negedge clk);
            ld_req = 1'b1; ld_addr = 16'h0023; ld_wdata = 32'hCAFEF00D;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_memop = MOP_B; cpu_addr = 16'h0022;
            #1;
            chk("ld_arb_ready", {30'h0, ld_ready, cpu_ready}, 32'h2);
            @(posedge clk); #1;
            ld_req = 1'b0; ld_addr = 16'hFFFF; ld_wdata = 32'h0;
            chk("ld_done", {29'h0, ld_done, cpu_done, cpu_ready}, 32'h4);
            @(posedge clk); #1;
            cpu_req = 1'b0; cpu_addr = 16'hFFFF;
            chk("ld_mem", mem[8], 32'hCAFEF00D);
            chk("ld_cpu_taken", {31'h0, cpu_ready}, 32'h0);
            for (int k = 2; k <= 8; k++) begin
                @(posedge clk); #1;
                if (cpu_done) begin
                    lat = k;
                    chk("ld_cpu_rdata", cpu_rdata, 32'hFFFFFFFE);
                    break;
                end
            end
            chk("ld_cpu_lat", lat, 3);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
